cp_sequencer_1506: RTL and testbench
====================================

CP_SEQUENCER_1506 -- requirements
Module: cp_sequencer_1506

Interface
REQ-001 SHALL have parameter LAT_ADD, default 1, meaning WAIT cycles after an ADD issue.
REQ-002 SHALL have parameter LAT_SUB, default 1, meaning WAIT cycles after a SUB issue.
REQ-003 SHALL have parameter LAT_MUL, default 4, meaning WAIT cycles after a MUL (multiply+reduce) issue; every LAT_* value is at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports prog_we (input, 1), prog_addr (input, 6) and prog_data (input, 24): host write port into program memory.
REQ-007 SHALL have ports start (input, 1) and iter_cnt (input, 16): run request and loop iteration count, both sampled in IDLE.
REQ-008 SHALL have ports command_cp (output, 24) and ins_in (output, 1): command word to the cryptoprocessor and its one-cycle issue strobe.
REQ-009 SHALL have ports busy (output, 1), done (output, 1), err (output, 1) and pc (output, 6).

Function
REQ-010 The instruction opcode SHALL be bits [23:20]: 0 = NOP, 1 = ADD, 2 = SUB, 3 = MUL, 0xE = LOOP (target in [5:0]), 0xF = HALT; other opcodes SHALL be treated as NOP.
REQ-011 The states SHALL be IDLE, FETCH, ISSUE, WAIT and DONE, and busy SHALL be 1 in every state except IDLE.
REQ-012 In IDLE, start=1 SHALL set pc=0, load iter_left=iter_cnt and go to FETCH; if iter_cnt=0 it SHALL go directly to DONE instead.
REQ-013 FETCH SHALL last one cycle (synchronous RAM read at pc) and then go to ISSUE.
REQ-014 In ISSUE with ADD/SUB/MUL, the block SHALL register command_cp = instruction, drive ins_in=1 for exactly that cycle, load the latency counter and go to WAIT.
REQ-015 WAIT SHALL last exactly LAT_op cycles and then increment pc and go to FETCH.
REQ-016 In ISSUE, NOP SHALL increment pc and go to FETCH with ins_in=0.
REQ-017 In ISSUE, LOOP SHALL decrement iter_left and set pc=target when iter_left>1, otherwise increment pc; in both cases it goes to FETCH without ins_in.
REQ-018 In ISSUE, HALT SHALL go to DONE.
REQ-019 Boundary: advancing pc past 63 (no HALT) SHALL set err=1 and go to DONE instead of wrapping.
REQ-020 DONE SHALL assert done=1 for one cycle and return to IDLE; err SHALL hold until the next accepted start.
REQ-021 command_cp SHALL hold its last issued value between issues; only the ins_in=1 cycle qualifies it.
REQ-022 start while busy SHALL be ignored.
REQ-023 prog_we while busy SHALL be ignored; prog_we and start together in IDLE SHALL perform the write and begin the run in the same cycle.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE and pc=0, iter_left=0, counter=0, command_cp=0, ins_in=0, busy=0, done=0, err=0.
REQ-025 Program memory SHALL NOT be cleared by reset.
REQ-026 Reset mid-run SHALL abort with no further ins_in.

Structure
REQ-027 The opcode constants, state encoding and widths (CMD_W=24, PC_W=6) SHALL live in the shared cryptoprocessor package.
REQ-028 The 64x24 synchronous program RAM SHALL be the single sub-module cp_prog_ram_64x24.

Verification
REQ-029 Program {ADD, MUL, HALT}, iter_cnt=1, start in cycle 0 -> ins_in=1 in cycles 2 and 5 with command_cp opcodes 1 and 3; done=1 in cycle 12; err=0.
REQ-030 Program {SUB, LOOP->0, HALT}, iter_cnt=3 -> exactly 3 ins_in pulses, each with opcode 2; then done=1, err=0.
REQ-031 iter_cnt=0 with start -> done=1 in cycle 1; zero ins_in pulses.
REQ-032 Sixty-four NOPs -> no ins_in; err=1 and done=1 after pc passes 63; err clears on the next start.
REQ-033 rst pulse during WAIT of a MUL -> all outputs 0 immediately; a restart executes the retained program correctly.
REQ-034 start and prog_we asserted while busy -> no restart and the RAM contents are unchanged (checked by read-back run).

Source files
------------

// File: rtl/cp_sequencer_1506_pkg.sv
// Shared cryptoprocessor definitions: widths, opcodes and sequencer state encoding.
package cp_sequencer_1506_pkg;

   localparam int CMD_W  = 24;
   localparam int PC_W   = 6;
   localparam int ITER_W = 16;
   localparam int CNT_W  = 8;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_MUL  = 4'h3,
      OP_LOOP = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_e;

   function automatic logic is_exec(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/cp_sequencer_1506_prog_ram.sv
// 64x24 program memory: one write port, registered read; contents survive reset.
module cp_prog_ram_64x24
   import cp_sequencer_1506_pkg::*;
(
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [PC_W-1:0]  waddr_i,
   input  logic [CMD_W-1:0] wdata_i,
   input  logic [PC_W-1:0]  raddr_i,
   output logic [CMD_W-1:0] rdata_o
);

   logic [CMD_W-1:0] mem_q [0:(1<<PC_W)-1];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/cp_sequencer_1506.sv
// Program sequencer feeding command words to the cryptoprocessor.
//   state | meaning
//   IDLE  | waiting for start; host may write program memory
//   FETCH | RAM read at pc in flight
//   ISSUE | decode instruction; ADD/SUB/MUL strobe ins_in
//   WAIT  | latency down-counter running for the issued op
//   DONE  | one-cycle done pulse, then back to IDLE
module cp_sequencer_1506
   import cp_sequencer_1506_pkg::*;
#(
   parameter int unsigned LAT_ADD = 1,
   parameter int unsigned LAT_SUB = 1,
   parameter int unsigned LAT_MUL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [CMD_W-1:0]  prog_data,
   input  logic              start,
   input  logic [ITER_W-1:0] iter_cnt,
   output logic [CMD_W-1:0]  command_cp,
   output logic              ins_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [PC_W-1:0]   pc
);

   seq_state_e        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CMD_W-1:0]  cmd_q, cmd_d;
   logic              err_q, err_d;
   logic [CMD_W-1:0]  instr;
   logic [3:0]        op;
   logic [CNT_W-1:0]  lat;
   logic              adv;

   cp_prog_ram_64x24 u_ram (
      .clk_i   (clk),
      .we_i    (prog_we && (state_q == ST_IDLE)),
      .waddr_i (prog_addr),
      .wdata_i (prog_data),
      .raddr_i (pc_q),
      .rdata_o (instr)
   );

   assign op = instr[CMD_W-1 -: 4];

   always_comb begin
      lat = CNT_W'(LAT_ADD);
      if (op == OP_SUB)      lat = CNT_W'(LAT_SUB);
      else if (op == OP_MUL) lat = CNT_W'(LAT_MUL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         iter_q  <= '0;
         cnt_q   <= '0;
         cmd_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         iter_q  <= iter_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      iter_d  = iter_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      err_d   = err_q;
      adv     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               pc_d    = '0;
               iter_d  = iter_cnt;
               err_d   = 1'b0;
               state_d = (iter_cnt == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_ISSUE;
         ST_ISSUE: begin
            if (is_exec(op)) begin
               cmd_d   = instr;
               cnt_d   = lat;
               state_d = ST_WAIT;
            end else if (op == OP_LOOP) begin
               if (iter_q > ITER_W'(1)) begin
                  iter_d  = iter_q - ITER_W'(1);
                  pc_d    = instr[PC_W-1:0];
                  state_d = ST_FETCH;
               end else begin
                  adv = 1'b1;
               end
            end else if (op == OP_HALT) begin
               state_d = ST_DONE;
            end else begin
               adv = 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt_q <= CNT_W'(1)) adv = 1'b1;
            else                    cnt_d = cnt_q - CNT_W'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Running off the end of program memory is an error, never a wrap to 0.
      if (adv) begin
         if (pc_q == '1) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
         end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_FETCH;
         end
      end
   end

   assign ins_in     = (state_q == ST_ISSUE) && is_exec(op);
   assign command_cp = ins_in ? instr : cmd_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign err        = err_q;
   assign pc         = pc_q;

endmodule

// File: tb/tb_cp_sequencer_1506.sv
// Self-checking bench for cp_sequencer_1506 against a cycle-count reference model.
module tb_cp_sequencer_1506;

   localparam int LA = 1, LS = 1, LM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        prog_we = 1'b0;
   logic [5:0]  prog_addr = '0;
   logic [23:0] prog_data = '0;
   logic        start = 1'b0;
   logic [15:0] iter_cnt = '0;
   logic [23:0] command_cp;
   logic        ins_in, busy, done, err;
   logic [5:0]  pc;

   int n_vec = 0;
   int n_bad = 0;

   logic [23:0] tb_mem [64];
   int          exp_cyc[$];
   logic [23:0] exp_cmd[$];
   int          exp_done;
   logic        exp_err;
   int          obs_cyc[$];
   logic [23:0] obs_cmd[$];

   cp_sequencer_1506 #(.LAT_ADD(LA), .LAT_SUB(LS), .LAT_MUL(LM)) dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .iter_cnt(iter_cnt),
      .command_cp(command_cp), .ins_in(ins_in), .busy(busy), .done(done),
      .err(err), .pc(pc)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] mk(input logic [3:0] op, input logic [19:0] low);
      return {op, low};
   endfunction

   // Cycle 0 = cycle in which start is sampled; a fetch at cycle f issues at f+1.
   task automatic model(input int iter);
      int f, lat, pc_m, it, nf;
      logic [23:0] w;
      logic adv;
      exp_cyc.delete(); exp_cmd.delete();
      exp_err = 1'b0;
      if (iter == 0) begin exp_done = 1; return; end
      f = 1; pc_m = 0; it = iter;
      forever begin
         w = tb_mem[pc_m];
         adv = 1'b1; nf = f + 2;
         case (w[23:20])
            4'h1, 4'h2, 4'h3: begin
               lat = (w[23:20] == 4'h1) ? LA : (w[23:20] == 4'h2) ? LS : LM;
               exp_cyc.push_back(f + 1); exp_cmd.push_back(w);
               nf = f + 2 + lat;
            end
            4'hE: if (it > 1) begin
               it--; pc_m = int'(w[5:0]); f = f + 2; adv = 1'b0;
            end
            4'hF: begin exp_done = f + 2; return; end
            default: ;
         endcase
         if (adv) begin
            if (pc_m == 63) begin exp_err = 1'b1; exp_done = nf; return; end
            pc_m++; f = nf;
         end
      end
   endtask

   task automatic load_word(input int a, input logic [23:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 6'(a); prog_data = d;
      tb_mem[a] = d;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   task automatic start_run(input int iter);
      @(negedge clk);
      iter_cnt = 16'(iter); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // poke_cyc > 0 drives start+prog_we (addr 0 <- HALT) during that busy cycle.
   task automatic run_check(input string name, input int iter, input int poke_cyc,
                            input int max_cyc, output int done_cyc);
      logic err_obs = 1'b0;
      model(iter);
      obs_cyc.delete(); obs_cmd.delete();
      done_cyc = -1;
      start_run(iter);
      for (int c = 1; c <= max_cyc && done_cyc < 0; c++) begin
         @(negedge clk);
         if (c == poke_cyc + 1) begin
            start = 1'b0; prog_we = 1'b0; iter_cnt = 16'(iter);
         end
         if (ins_in === 1'b1) begin obs_cyc.push_back(c); obs_cmd.push_back(command_cp); end
         if (done === 1'b1) begin done_cyc = c; err_obs = err; end
         if (poke_cyc > 0 && c == poke_cyc) begin
            start = 1'b1; prog_we = 1'b1; prog_addr = 6'd0;
            prog_data = mk(4'hF, 20'h0); iter_cnt = 16'd7;
         end
      end
      start = 1'b0; prog_we = 1'b0;
      n_vec++;
      if (obs_cyc.size() !== exp_cyc.size()) begin
         n_bad++;
         $display("FAIL %s issue_count got %0d want %0d", name, obs_cyc.size(), exp_cyc.size());
      end else begin
         for (int i = 0; i < exp_cyc.size(); i++) begin
            n_vec++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_cmd[i] !== exp_cmd[i]) begin
               n_bad++;
               $display("FAIL %s issue[%0d] got cyc %0d cmd %h want cyc %0d cmd %h",
                        name, i, obs_cyc[i], obs_cmd[i], exp_cyc[i], exp_cmd[i]);
            end
         end
      end
      n_vec++;
      if (done_cyc !== exp_done) begin
         n_bad++;
         $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, exp_done);
      end
      n_vec++;
      if (err_obs !== exp_err) begin
         n_bad++;
         $display("FAIL %s err got %b want %b", name, err_obs, exp_err);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      n_vec++;
      if ({command_cp, ins_in, busy, done, err, pc} !== '0) begin
         n_bad++;
         $display("FAIL %s outputs got cmd %h ins %b busy %b done %b err %b pc %0d want all 0",
                  name, command_cp, ins_in, busy, done, err, pc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 check_zero_outputs("reset");
      @(negedge clk); rst = 1'b0;
      @(negedge clk); check_zero_outputs("post_reset_idle");
   endtask

   task automatic load_add_mul_halt();
      load_word(0, mk(4'h1, 20'h12345));
      load_word(1, mk(4'h3, 20'hABCDE));
      load_word(2, mk(4'hF, 20'h0));
   endtask

   task automatic test_add_mul_halt();
      int dc;
      load_add_mul_halt();
      run_check("add_mul_halt", 1, 0, 100, dc);
      n_vec++;
      if (obs_cyc.size() != 2 || obs_cyc[0] !== 2 || obs_cyc[1] !== 5 ||
          obs_cmd[0][23:20] !== 4'h1 || obs_cmd[1][23:20] !== 4'h3 || dc !== 12) begin
         n_bad++;
         $display("FAIL add_mul_halt_fixed got n=%0d done=%0d want issues at 2,5 ops 1,3 done 12",
                  obs_cyc.size(), dc);
      end
   endtask

   task automatic test_loop();
      int dc;
      logic ok;
      load_word(0, mk(4'h2, 20'h0F0F0));
      load_word(1, mk(4'hE, 20'h00000));
      load_word(2, mk(4'hF, 20'h0));
      run_check("sub_loop", 3, 0, 200, dc);
      ok = (obs_cyc.size() == 3);
      foreach (obs_cmd[i]) if (obs_cmd[i][23:20] !== 4'h2) ok = 1'b0;
      n_vec++;
      if (!ok || dc < 0) begin
         n_bad++;
         $display("FAIL sub_loop_fixed got %0d pulses done=%0d want 3 SUB pulses and done", obs_cyc.size(), dc);
      end
   endtask

   task automatic test_zero_iter();
      int dc;
      run_check("zero_iter", 0, 0, 20, dc);
      n_vec++;
      if (dc !== 1 || obs_cyc.size() != 0) begin
         n_bad++;
         $display("FAIL zero_iter_fixed got done=%0d pulses=%0d want done 1 pulses 0", dc, obs_cyc.size());
      end
   endtask

   task automatic test_nop_overflow();
      int dc;
      for (int a = 0; a < 64; a++) load_word(a, mk(4'h0, 20'(a)));
      run_check("nop_overflow", 2, 0, 400, dc);
      @(negedge clk);
      n_vec++;
      if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL err_hold got err %b done %b busy %b want 1 0 0", err, done, busy);
      end
      run_check("err_clear", 0, 0, 20, dc);
   endtask

   task automatic test_reset_mid_run();
      int dc;
      load_add_mul_halt();
      start_run(1);
      for (int c = 1; c <= 7; c++) @(negedge clk);
      n_vec++;
      if (busy !== 1'b1 || ins_in !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_run_wait got busy %b ins %b want 1 0", busy, ins_in);
      end
      #2 rst = 1'b1;
      #1 check_zero_outputs("reset_mid_wait");
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check_zero_outputs("reset_held");
      end
      rst = 1'b0;
      run_check("restart_after_reset", 1, 0, 100, dc);
   endtask

   task automatic test_busy_ignore();
      int dc;
      load_add_mul_halt();
      run_check("busy_poke", 1, 3, 100, dc);
      run_check("busy_readback", 1, 0, 100, dc);
   endtask

   task automatic test_random();
      int dc, len, r;
      logic [3:0] op;
      for (int t = 0; t < 10; t++) begin
         len = $urandom_range(1, 10);
         for (int a = 0; a < len; a++) begin
            r = $urandom_range(0, 9);
            case (r)
               0, 1: op = 4'h1;
               2:    op = 4'h2;
               3:    op = 4'h3;
               5:    op = 4'($urandom_range(4, 13));
               6, 7: op = 4'hE;
               default: op = 4'h0;
            endcase
            if (op == 4'hE) load_word(a, {op, 14'($urandom), 6'($urandom_range(0, a))});
            else            load_word(a, {op, 20'($urandom)});
         end
         load_word(len, mk(4'hF, 20'($urandom)));
         run_check($sformatf("random%0d", t), $urandom_range(0, 4), 0, 2000, dc);
      end
   endtask

   initial begin
      test_reset();
      test_add_mul_halt();
      test_loop();
      test_zero_iter();
      test_nop_overflow();
      test_reset_mid_run();
      test_busy_ignore();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
